// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit seven-segment scan controller with per-frame snapshot, anti-ghost guard and blink.
// Define FND_BLINK_EN to build the blink counter; otherwise blink_in is ignored.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV    = 100_000,
  parameter int GUARD       = 4,
  parameter int BLINK_SCANS = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dot_in,
  input  logic [3:0]  blank_in,
  input  logic [3:0]  blink_in,
  output logic [1:0]  fnd_sel,
  output logic [3:0]  fnd_com,
  output logic [7:0]  fnd_font
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int GRD_W = $clog2(GUARD + 2);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [GRD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [15:0]      sh_digits_q, sh_digits_d;
  logic [3:0]       sh_dot_q, sh_dot_d;
  logic [3:0]       sh_blank_q, sh_blank_d;
  logic [3:0]       com_q, com_d;
  logic [7:0]       font_q, font_d;
  logic             scan_tick;
  logic             snap;
  logic             blink_dark;
  logic             dark;
  logic [3:0]       cur_bcd;
  logic [6:0]       seg;

  assign scan_tick = en && (div_cnt_q == DIV_LAST);
  // Shadow is transparent while disabled and reloads only at the frame boundary.
  assign snap      = !en || (scan_tick && sel_q == 2'd3);

  always_comb begin
    div_cnt_d   = div_cnt_q;
    sel_d       = sel_q;
    guard_cnt_d = guard_cnt_q;
    if (en) div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    if (scan_tick) begin
      sel_d       = sel_q + 2'd1;
      guard_cnt_d = GRD_LOAD;
    end else if (guard_cnt_q != '0) begin
      guard_cnt_d = guard_cnt_q - GRD_W'(1);
    end
    sh_digits_d = snap ? digits_in : sh_digits_q;
    sh_dot_d    = snap ? dot_in    : sh_dot_q;
    sh_blank_d  = snap ? blank_in  : sh_blank_q;
  end

`ifdef FND_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_SCANS + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SCANS - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [3:0]       sh_blink_q, sh_blink_d;

  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (scan_tick) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
    sh_blink_d = snap ? blink_in : sh_blink_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_blink_q    <= '0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_blink_q    <= sh_blink_d;
    end
  end

  assign blink_dark = blink_phase_q && sh_blink_q[sel_q];
`else
  logic unused_blink;
  assign unused_blink = ^blink_in;
  assign blink_dark   = 1'b0;
`endif

  assign cur_bcd = sh_digits_q[{sel_q, 2'b00} +: 4];

  always_comb begin
    case (cur_bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  end

  assign dark = !en || (guard_cnt_q != '0) || sh_blank_q[sel_q] || blink_dark;

  always_comb begin
    com_d  = 4'b1111;
    font_d = 8'hFF;
    if (!dark) begin
      com_d  = ~(4'b0001 << sel_q);
      font_d = {~sh_dot_q[sel_q], seg};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q   <= '0;
      sel_q       <= 2'd0;
      guard_cnt_q <= '0;
      sh_digits_q <= '0;
      sh_dot_q    <= '0;
      sh_blank_q  <= '0;
      com_q       <= 4'b1111;
      font_q      <= 8'hFF;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sel_q       <= sel_d;
      guard_cnt_q <= guard_cnt_d;
      sh_digits_q <= sh_digits_d;
      sh_dot_q    <= sh_dot_d;
      sh_blank_q  <= sh_blank_d;
      com_q       <= com_d;
      font_q      <= font_d;
    end
  end

  assign fnd_sel  = sel_q;
  assign fnd_com  = com_q;
  assign fnd_font = font_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: two instances (no-guard and guarded) share stimulus.
// Expected outputs come from a slot-arithmetic reference model; a monitor pops and compares.
module tb_fnd_scan_ctrl;

  localparam int SD_A = 4;
  localparam int G_A  = 0;
  localparam int SD_B = 8;
  localparam int G_B  = 2;
  localparam int BS   = 2;
  localparam int BIG  = 1 << 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dot = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  blink = '0;
  logic [1:0]  sel_a, sel_b;
  logic [3:0]  com_a, com_b;
  logic [7:0]  font_a, font_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fnd_scan_ctrl #(.SCAN_DIV(SD_A), .GUARD(G_A), .BLINK_SCANS(BS)) u_a (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits), .dot_in(dot),
    .blank_in(blank), .blink_in(blink), .fnd_sel(sel_a), .fnd_com(com_a), .fnd_font(font_a));

  fnd_scan_ctrl #(.SCAN_DIV(SD_B), .GUARD(G_B), .BLINK_SCANS(BS)) u_b (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits), .dot_in(dot),
    .blank_in(blank), .blink_in(blink), .fnd_sel(sel_b), .fnd_com(com_b), .fnd_font(font_b));

  typedef struct {
    int              cyc;
    logic [1:0][3:0] com;
    logic [1:0][7:0] font;
    logic [1:0][1:0] sel;
  } exp_t;

  exp_t q[$];

  logic [7:0] font_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Model state: enabled-cycle count, cycles since the last digit change, frame snapshot.
  int          ec [2];
  int          since [2];
  logic [15:0] sh_dig [2];
  logic [3:0]  sh_dot [2];
  logic [3:0]  sh_blank [2];
  logic [3:0]  sh_blink [2];

  function automatic int sdiv(input int i);
    return (i == 0) ? SD_A : SD_B;
  endfunction

  function automatic int grd(input int i);
    return (i == 0) ? G_A : G_B;
  endfunction

  function automatic void predict(input int i, input logic en_v,
                                  output logic [3:0] com, output logic [7:0] font);
    int         s;
    int         ph;
    int         guard_left;
    logic [3:0] bcd;
    logic [7:0] pat;
    logic       dk;
    s = (ec[i] / sdiv(i)) % 4;
`ifdef FND_BLINK_EN
    ph = ((ec[i] / sdiv(i)) / BS) % 2;
`else
    ph = 0;
`endif
    guard_left = (since[i] < grd(i)) ? grd(i) - since[i] : 0;
    bcd = sh_dig[i][4*s +: 4];
    dk = !en_v || guard_left != 0 || sh_blank[i][s] || (sh_blink[i][s] && ph == 1);
    com  = 4'b1111;
    font = 8'hFF;
    if (!dk) begin
      com[s] = 1'b0;
      pat = (bcd < 10) ? font_tbl[bcd] : 8'hFF;
      font = {~sh_dot[i][s], pat[6:0]};
    end
  endfunction

  // Push the expectation for the coming edge, advance the model, then wait for that edge.
  task automatic drive_cycle();
    exp_t e;
    logic [3:0] c;
    logic [7:0] f;
    bit tick;
    bit load;
    e.cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        c = 4'b1111;
        f = 8'hFF;
        ec[i] = 0;
        since[i] = BIG;
        sh_dig[i] = '0;
        sh_dot[i] = '0;
        sh_blank[i] = '0;
        sh_blink[i] = '0;
      end else begin
        predict(i, en, c, f);
        tick = en && (ec[i] % sdiv(i) == sdiv(i) - 1);
        load = !en || (tick && ((ec[i] / sdiv(i)) % 4 == 3));
        if (load) begin
          sh_dig[i] = digits;
          sh_dot[i] = dot;
          sh_blank[i] = blank;
          sh_blink[i] = blink;
        end
        if (en) ec[i]++;
        since[i] = tick ? 0 : ((since[i] < BIG) ? since[i] + 1 : BIG);
      end
      e.com[i]  = c;
      e.font[i] = f;
      e.sel[i]  = 2'((ec[i] / sdiv(i)) % 4);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) drive_cycle();
  endtask

  task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("com",  0, {4'h0, com_a},  {4'h0, e.com[0]});
        chk("font", 0, font_a,         e.font[0]);
        chk("sel",  0, {6'h0, sel_a},  {6'h0, e.sel[0]});
        chk("com",  1, {4'h0, com_b},  {4'h0, e.com[1]});
        chk("font", 1, font_b,         e.font[1]);
        chk("sel",  1, {6'h0, sel_b},  {6'h0, e.sel[1]});
      end
    end
  end

  initial begin : driver
    rst = 1'b1;
    en = 1'b1;
    digits = 16'($urandom);
    dot = 4'($urandom);
    blank = 4'($urandom);
    blink = 4'($urandom);
    run(2);
    rst = 1'b0;
    en = 1'b0;
    digits = 16'h1234;
    dot = 4'b0000;
    blank = 4'b0000;
    blink = 4'b0000;
    run(2);
    en = 1'b1;
    run(40);
    digits = 16'h5678;
    run(70);
    dot = 4'b0001;
    blank = 4'b0100;
    run(70);
    dot = 4'b0000;
    blank = 4'b0000;
    blink = 4'b0001;
    run(140);
    run(21);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(40);
    rst = 1'b1;
    digits = 16'($urandom);
    run(1);
    rst = 1'b0;
    run(40);
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 49) == 0) en = !en;
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 39) == 0) dot = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 39) == 0) blink = 4'($urandom);
      drive_cycle();
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
